// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one UART transmitter between a host slot (0) and an echo slot (1).
// Arbitrates, strobes the transmitter, waits for completion, and enforces an inter-frame gap.
module uart_tx_sched #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              tick,
  input  logic              rst,
  input  logic [31:0]       csr,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] tx_word,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              irq_done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_en;
  logic [3:0]        w_gap_len;
  logic              w_fixed;
  logic              w_clr_err;
  logic              w_grant;
  logic              w_accept;
  logic              w_frame_done;
  logic              w_timeout;
  logic [1:0]        w_ready;
  logic              r_last_grant;
  logic              r_tx_start;
  logic              r_irq;
  logic              r_err;
  logic [DATA_W-1:0] r_tx_word;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [3:0]        r_gap;

  assign w_en      = csr[7];
  assign w_gap_len = csr[11:8];
  assign w_fixed   = csr[12];
  assign w_clr_err = csr[13];

  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    w_ready      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_en && (|req_valid)) begin
          // Round-robin tie goes to the slot that did not win last time.
          if (w_fixed) begin
            w_grant = ~req_valid[0];
          end else if (&req_valid) begin
            w_grant = ~r_last_grant;
          end else begin
            w_grant = req_valid[1];
          end
          w_accept = 1'b1;
          w_ready  = w_grant ? 2'b10 : 2'b01;
          w_next   = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          w_frame_done = 1'b1;
          w_next       = (w_gap_len != 4'd0) ? S_GAP : S_IDLE;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_GAP: begin
        if (r_gap <= 4'd1) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_GAP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_tx_word    <= '0;
      r_last_grant <= 1'b1;
      r_tx_start   <= 1'b0;
    end else begin
      r_tx_start <= w_accept;
      if (w_accept) begin
        r_tx_word    <= w_grant ? req_data1 : req_data0;
        r_last_grant <= w_grant;
      end else begin
        r_tx_word    <= r_tx_word;
        r_last_grant <= r_last_grant;
      end
    end
  end

  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_irq       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_irq <= w_frame_done;
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_WAIT) && !w_frame_done && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_gap <= 4'd0;
    end else if (w_frame_done) begin
      r_gap <= w_gap_len;
    end else if ((r_state == S_GAP) && (r_gap != 4'd0)) begin
      r_gap <= r_gap - 4'd1;
    end else begin
      r_gap <= r_gap;
    end
  end

  // A timeout in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge tick or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (w_clr_err) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign req_ready   = w_ready & {2{~rst}};
  assign tx_word     = r_tx_word;
  assign tx_start    = r_tx_start;
  assign busy        = (r_state != S_IDLE);
  assign irq_done    = r_irq;
  assign frame_cnt   = r_frame_cnt;
  assign err_timeout = r_err;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit scheduler that sits in front of the UART transmitter and shares it between two requesters (host write path, slot 0; auto-response/echo path, slot 1).
- Arbitrates between the two slots and captures the winning word.
- Starts the transmitter with a one-cycle load strobe, then waits for its done indication.
- Enforces a programmable inter-frame gap between frames.
- Maintains a frame counter, a done interrupt pulse and a sticky timeout error.

Parameters:
DATA_W, 32, width of request words and tx_word
TIMEOUT, 1024, maximum cycles in WAIT before a frame is abandoned (must be >= 2)
CNT_W, 16, width of frame_cnt

Ports:
tick  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
csr  input  32  control: [7] enable, [11:8] gap length in cycles, [12] 1 = fixed priority (slot 0 wins) / 0 = round-robin, [13] clear err_timeout (level)
req_valid  input  2  per-slot request; held high until accepted
req_data0  input  DATA_W  slot 0 word
req_data1  input  DATA_W  slot 1 word
req_ready  output  2  per-slot accept; transfer occurs when req_valid[i] & req_ready[i]
tx_word  output  DATA_W  word presented to the transmitter's regdata input
tx_start  output  1  one-cycle load strobe to the transmitter
tx_done  input  1  transmitter frame-complete indication
busy  output  1  high whenever state != IDLE
irq_done  output  1  one-cycle pulse per completed frame
frame_cnt  output  CNT_W  completed-frame count
err_timeout  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): state=IDLE; tx_word=0, tx_start=0, req_ready=0, irq_done=0, frame_cnt=0, err_timeout=0, gap and timeout counters=0, last_grant=1 (slot 0 wins the first round-robin tie). Reset during any state aborts immediately; no strobe or pulse escapes.
- States: IDLE, LOAD, WAIT, GAP.
- IDLE:
  - If csr[7]=1 and |req_valid, the winner w is chosen combinationally and req_ready[w]=1 in this cycle (never both bits).
  - On the edge: tx_word <= req_data_w, last_grant <= w, state -> LOAD.
  - If csr[7]=0 or no request: req_ready=0 and state stays IDLE.
- Arbitration:
  - csr[12]=1: slot 0 always wins when valid.
  - csr[12]=0: a single valid slot wins; if both are valid, the slot != last_grant wins.
- LOAD: tx_start=1 for exactly this cycle; timeout counter cleared; -> WAIT unconditionally.
- WAIT:
  - tx_done=1: frame_cnt += 1 (wraps all-ones -> 0), irq_done=1 registered for one cycle; -> GAP if csr[11:8] != 0, else -> IDLE.
  - Otherwise the counter increments. On the cycle it equals TIMEOUT-1 without tx_done: err_timeout <= 1, no count increment, no irq; -> IDLE.
- GAP: gap counter loaded with csr[11:8] on WAIT exit and decremented each cycle; -> IDLE in the cycle it reaches 1. A gap of N gives exactly N GAP cycles.
- tx_done is ignored outside WAIT.
- tx_word holds its value until the next capture.
- Clearing csr[7] mid-frame: the current frame completes normally (WAIT/GAP run to the end); no new grant is issued.
- err_timeout is cleared while csr[13]=1. A set in the same cycle as a clear wins.
- Best-case throughput: 1 IDLE + 1 LOAD + transmitter time + gap cycles per frame.

Test Plan:
- Single request: csr[7]=1, csr[11:8]=0, req_valid=01, req_data0=0xA5A5_0001 -> req_ready=01 for 1 cycle; tx_start high the next cycle; tx_word=0xA5A5_0001; tx_done after 20 cycles -> irq_done pulse, frame_cnt=1, back in IDLE.
- Round-robin: csr[12]=0, both slots valid for 4 frames -> grant order 0,1,0,1 and frame_cnt=4. Repeat with csr[12]=1 -> order 0,0,0,0.
- Gap: csr[11:8]=5 -> exactly 5 GAP cycles between the tx_done cycle+1 and the next req_ready; busy stays high throughout.
- Timeout: TIMEOUT=16, tx_done never asserted -> err_timeout=1 at the 16th WAIT cycle, frame_cnt unchanged, IDLE. Then csr[13]=1 for 1 cycle -> err_timeout=0.
- Enable drop mid-WAIT: csr[7] cleared during WAIT, tx_done arrives -> frame counted, IDLE, req_valid=11 receives no ready.
- Async reset asserted during WAIT -> all outputs 0 immediately (no edge needed); frame_cnt=0; the first grant after release goes to slot 0.
